adc_input_multi: RTL and testbench

- Parametrised successor to the single AD7980 SPI reader: serves NUM_ADC AD7980-class serial ADCs in parallel, with ADC_BITS-wide words, one shared SCLK and a per-ADC CS.
- Sequenced by the main command state machine through main_state/channel, the same as the existing ADC path.
- Adds over the single reader: per-ADC enables, double-buffered output (a partial word is never visible), an optional two's-complement output format, a one-cycle data_valid strobe and a conversion counter.
- Sits beside the analog-in/out logic and feeds the aux-ADC words into the USB data frame.

---
 rtl/adc_input_multi_pkg.sv | 21 ++
 rtl/adc_input_multi_if.sv | 27 ++
 rtl/adc_input_multi_shift_lane.sv | 46 ++++
 rtl/adc_input_multi.sv | 119 +++++++++++
 tb/tb_adc_input_multi.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/adc_input_multi_pkg.sv
// Shared constants for the multi-ADC serial reader.
//   MS_*        : main command state-machine codes that sequence the transfer
//   FMT_*       : output word format selector (raw offset-binary or two's-complement)
//   lane_phase_e: transfer phase, tracked once for all lanes
package adc_input_multi_pkg;

  localparam logic [31:0] MS_WAIT    = 32'd99;
  localparam logic [31:0] MS_CLK1_A  = 32'd100;
  localparam logic [31:0] MS_CLK18_C = 32'd170;

  localparam int FMT_RAW  = 0;
  localparam int FMT_TWOS = 1;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ARM,
    PH_SHIFT,
    PH_PUBLISH
  } lane_phase_e;

endpackage

// File: rtl/adc_input_multi_if.sv
// Bus between the frame sequencer and the ADC reader.
//   master: drives main_state/channel/adc_enable and the ADC serial data
//   slave : the reader; returns CS/SCLK, the completed words, valid strobe, count
interface adc_input_multi_if #(
  parameter int NUM_ADC  = 8,
  parameter int ADC_BITS = 16
);
  logic [31:0]                  main_state;
  logic [5:0]                   channel;
  logic [NUM_ADC-1:0]           adc_enable;
  logic [NUM_ADC-1:0]           ADC_DOUT;
  logic [NUM_ADC-1:0]           ADC_CS;
  logic                         ADC_SCLK;
  logic [NUM_ADC*ADC_BITS-1:0]  ADC_data;
  logic                         data_valid;
  logic [15:0]                  conv_count;

  modport master (
    output main_state, channel, adc_enable, ADC_DOUT,
    input  ADC_CS, ADC_SCLK, ADC_data, data_valid, conv_count
  );

  modport slave (
    input  main_state, channel, adc_enable, ADC_DOUT,
    output ADC_CS, ADC_SCLK, ADC_data, data_valid, conv_count
  );
endinterface

// File: rtl/adc_input_multi_shift_lane.sv
// One ADC lane: enable latch, MSB-first shift register and output word.
//   arm      : channel 0 slot; latch en_in, clear the shift register
//   shift_en : channel 1..ADC_BITS slot; bit_sel is the bit written this slot
//   done     : last bit slot; publish {shift, dout} to data
//   en_q     : latched enable, held for the whole frame
//   data     : last completed word (held while the lane is disabled)
module adc_shift_lane
  import adc_input_multi_pkg::*;
#(
  parameter int ADC_BITS  = 16,
  parameter int TWOS_COMP = FMT_RAW
) (
  input  logic                dataclk,
  input  logic                reset,
  input  logic                arm,
  input  logic                shift_en,
  input  logic                done,
  input  logic [5:0]          bit_sel,
  input  logic                en_in,
  input  logic                dout,
  output logic                en_q,
  output logic [ADC_BITS-1:0] data
);

  localparam logic [ADC_BITS-1:0] MSB_FLIP =
    (TWOS_COMP == FMT_TWOS) ? {1'b1, {(ADC_BITS-1){1'b0}}} : '0;

  logic [ADC_BITS-1:0] shreg;

  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      en_q  <= 1'b0;
      shreg <= '0;
      data  <= '0;
    end else if (arm) begin
      en_q  <= en_in;
      shreg <= '0;
    end else if (shift_en && en_q) begin
      for (int i = 0; i < ADC_BITS; i++)
        if (bit_sel == 6'(i)) shreg[i] <= dout;
      // The LSB arrives on the completing edge, so merge it directly.
      if (done) data <= {shreg[ADC_BITS-1:1], dout} ^ MSB_FLIP;
    end
  end

endmodule

// File: rtl/adc_input_multi.sv
// Parallel reader for NUM_ADC AD7980-class serial ADCs sharing one SCLK.
//   dataclk, reset : clock, async active-high reset
//   bus (slave)    : main_state/channel sequencing, adc_enable, ADC_DOUT in;
//                    ADC_CS, ADC_SCLK, ADC_data, data_valid, conv_count out
// data_valid pulses and conv_count steps one edge after a word is published.
module adc_input_multi
  import adc_input_multi_pkg::*;
#(
  parameter int          NUM_ADC    = 8,
  parameter int          ADC_BITS   = 16,
  parameter int          TWOS_COMP  = FMT_RAW,
  parameter logic [31:0] ms_wait    = MS_WAIT,
  parameter logic [31:0] ms_clk1_a  = MS_CLK1_A,
  parameter logic [31:0] ms_clk18_c = MS_CLK18_C
) (
  input logic dataclk,
  input logic reset,
  adc_input_multi_if.slave bus
);

  localparam logic [5:0] BITS6 = 6'(ADC_BITS);

  logic                               ms_clk1, arm, shift_en, done;
  logic [5:0]                         bit_sel;
  logic [NUM_ADC-1:0]                 en_q;
  logic [NUM_ADC-1:0][ADC_BITS-1:0]   lane_data;
  logic [NUM_ADC-1:0]                 cs_q;
  logic                               sclk_q, valid_q, pub;
  logic [15:0]                        cnt_q;
  lane_phase_e                        ph, ph_nxt;

  assign ms_clk1  = (bus.main_state == ms_clk1_a);
  assign arm      = ms_clk1 && (bus.channel == 6'd0);
  assign shift_en = ms_clk1 && (bus.channel != 6'd0) && (bus.channel <= BITS6);
  assign done     = ms_clk1 && (bus.channel == BITS6);
  assign bit_sel  = BITS6 - bus.channel;

  for (genvar k = 0; k < NUM_ADC; k++) begin : g_lane
    adc_shift_lane #(.ADC_BITS(ADC_BITS), .TWOS_COMP(TWOS_COMP)) u_lane (
      .dataclk  (dataclk),
      .reset    (reset),
      .arm      (arm),
      .shift_en (shift_en),
      .done     (done),
      .bit_sel  (bit_sel),
      .en_in    (bus.adc_enable[k]),
      .dout     (bus.ADC_DOUT[k]),
      .en_q     (en_q[k]),
      .data     (lane_data[k])
    );
  end

  // CS / SCLK follow the slot; CS at channel 0 uses the enables being latched now.
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      cs_q   <= '1;
      sclk_q <= 1'b0;
    end else if (bus.main_state == ms_wait) begin
      cs_q   <= '1;
      sclk_q <= 1'b0;
    end else if (ms_clk1) begin
      if (bus.channel == 6'd0) begin
        cs_q   <= ~bus.adc_enable;
        sclk_q <= 1'b0;
      end else if (bus.channel <= BITS6) begin
        cs_q   <= ~en_q;
        sclk_q <= 1'b1;
      end else begin
        cs_q   <= '1;
        sclk_q <= 1'b0;
      end
    end else if (bus.main_state == ms_clk18_c) begin
      sclk_q <= 1'b0;
    end
  end

  // Phase FSM: state register
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) ph <= PH_IDLE;
    else       ph <= ph_nxt;
  end

  // Phase FSM: next state. Completion wins; with no lane enabled nothing publishes.
  always_comb begin
    ph_nxt = ph;
    if (done && |en_q)  ph_nxt = PH_PUBLISH;
    else if (arm)       ph_nxt = PH_ARM;
    else begin
      case (ph)
        PH_ARM:     if (shift_en) ph_nxt = PH_SHIFT;
        PH_SHIFT:   if (bus.main_state == ms_wait) ph_nxt = PH_IDLE;
        PH_PUBLISH: ph_nxt = PH_IDLE;
        default:    ph_nxt = ph;
      endcase
    end
  end

  // Phase FSM: outputs
  always_comb begin
    pub = (ph == PH_PUBLISH);
  end

  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= pub;
      cnt_q   <= cnt_q + 16'(pub);
    end
  end

  assign bus.ADC_CS     = cs_q;
  assign bus.ADC_SCLK   = sclk_q;
  assign bus.ADC_data   = lane_data;
  assign bus.data_valid = valid_q;
  assign bus.conv_count = cnt_q;

endmodule

// File: tb/tb_adc_input_multi.sv
module tb_adc_input_multi;
  import adc_input_multi_pkg::*;

  logic dataclk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] model [8];
  int   s, v;

  always #5 dataclk = ~dataclk;

  adc_input_multi_if #(.NUM_ADC(8), .ADC_BITS(16)) ia();
  adc_input_multi_if #(.NUM_ADC(2), .ADC_BITS(18)) ib();

  adc_input_multi #(.NUM_ADC(8), .ADC_BITS(16), .TWOS_COMP(0)) ua (
    .dataclk(dataclk), .reset(reset), .bus(ia));
  adc_input_multi #(.NUM_ADC(2), .ADC_BITS(18), .TWOS_COMP(1)) ub (
    .dataclk(dataclk), .reset(reset), .bus(ib));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge dataclk); #1;
  endtask

  task automatic chk_lanes(input string tag);
    for (int k = 0; k < 8; k++) chk(tag, 64'(ia.ADC_data[k*16 +: 16]), 64'(model[k]));
  endtask

  // One 16-bit frame on DUT A; lane k sends base + k*step MSB first.
  task automatic frame_a(input logic [15:0] base, input logic [15:0] step,
                         input logic [7:0] en, input logic [7:0] en_mid,
                         input logic [7:0] cs_exp, input int rst_at,
                         output int sclk_hi, output int vld_hi);
    logic [15:0] w;
    sclk_hi = 0;
    vld_hi  = 0;
    for (int c = 0; c <= 16; c++) begin
      ia.main_state = MS_CLK1_A;
      ia.channel    = 6'(c);
      if (c == 0) ia.adc_enable = en;
      if (c == 8) ia.adc_enable = en_mid;
      for (int k = 0; k < 8; k++) begin
        w = base + 16'(k) * step;
        ia.ADC_DOUT[k] = (c == 0) ? 1'b0 : w[16-c];
      end
      if (c == rst_at) begin
        reset = 1'b1;
        #1;
        chk("rst_mid_cs",    64'(ia.ADC_CS), 64'hFF);
        chk("rst_mid_sclk",  64'(ia.ADC_SCLK), 64'h0);
        chk("rst_mid_data",  64'(|ia.ADC_data), 64'h0);
        chk("rst_mid_valid", 64'(ia.data_valid), 64'h0);
        chk("rst_mid_count", 64'(ia.conv_count), 64'h0);
        reset = 1'b0;
        ia.main_state = MS_WAIT;
        return;
      end
      tick();
      sclk_hi += int'(ia.ADC_SCLK);
      vld_hi  += int'(ia.data_valid);
      if (c == 4 || c == 12) chk("cs_xfer", 64'(ia.ADC_CS), 64'(cs_exp));
      ia.main_state = MS_CLK18_C;
      tick();
      sclk_hi += int'(ia.ADC_SCLK);
      vld_hi  += int'(ia.data_valid);
    end
    ia.main_state = MS_WAIT;
    tick();
    vld_hi += int'(ia.data_valid);
    chk("cs_idle", 64'(ia.ADC_CS), 64'hFF);
    tick();
    vld_hi += int'(ia.data_valid);
  endtask

  initial begin
    reset = 1'b1;
    ia.main_state = MS_WAIT; ia.channel = '0; ia.adc_enable = '0; ia.ADC_DOUT = '0;
    ib.main_state = MS_WAIT; ib.channel = '0; ib.adc_enable = '0; ib.ADC_DOUT = '0;
    for (int k = 0; k < 8; k++) model[k] = '0;
    repeat (2) tick();
    chk("reset_cs",    64'(ia.ADC_CS), 64'hFF);
    chk("reset_sclk",  64'(ia.ADC_SCLK), 64'h0);
    chk("reset_data",  64'(|ia.ADC_data), 64'h0);
    chk("reset_valid", 64'(ia.data_valid), 64'h0);
    chk("reset_count", 64'(ia.conv_count), 64'h0);
    reset = 1'b0;
    tick();

    // All lanes enabled, words 0xA5A5+k
    frame_a(16'hA5A5, 16'h0001, 8'hFF, 8'hFF, 8'h00, -1, s, v);
    chk("t1_sclk_hi", 64'(s), 64'd16);
    chk("t1_valid",   64'(v), 64'd1);
    chk("t1_count",   64'(ia.conv_count), 64'd1);
    for (int k = 0; k < 8; k++) model[k] = 16'hA5A5 + 16'(k);
    chk_lanes("t1_data");

    // Only lanes 0 and 2 enabled
    frame_a(16'h1234, 16'h0111, 8'h05, 8'h05, 8'hFA, -1, s, v);
    chk("t2_valid", 64'(v), 64'd1);
    chk("t2_count", 64'(ia.conv_count), 64'd2);
    model[0] = 16'h1234;
    model[2] = 16'h1456;
    chk_lanes("t2_data");

    // Enables dropped mid-frame: this frame is unaffected
    frame_a(16'h0F0F, 16'h1000, 8'hFF, 8'h00, 8'h00, -1, s, v);
    chk("t3_valid", 64'(v), 64'd1);
    chk("t3_count", 64'(ia.conv_count), 64'd3);
    for (int k = 0; k < 8; k++) model[k] = 16'h0F0F + 16'(k) * 16'h1000;
    chk_lanes("t3_data");

    // Reset at channel 9 aborts the frame
    frame_a(16'hFFFF, 16'h0001, 8'hFF, 8'hFF, 8'h00, 9, s, v);
    tick(); tick();
    chk("t4_no_valid", 64'(v) + 64'(ia.data_valid), 64'd0);
    chk("t4_data_zero", 64'(|ia.ADC_data), 64'h0);
    frame_a(16'hA5A5, 16'h0001, 8'hFF, 8'hFF, 8'h00, -1, s, v);
    chk("t4_valid", 64'(v), 64'd1);
    chk("t4_count", 64'(ia.conv_count), 64'd1);
    for (int k = 0; k < 8; k++) model[k] = 16'hA5A5 + 16'(k);
    chk_lanes("t4_data");

    // 18-bit two's-complement DUT: lane0 sends 0x00000, lane1 sends 0x3FFFF
    v = 0;
    for (int c = 0; c <= 18; c++) begin
      ib.main_state = MS_CLK1_A;
      ib.channel    = 6'(c);
      if (c == 0) ib.adc_enable = 2'b11;
      ib.ADC_DOUT = (c == 0) ? 2'b00 : 2'b10;
      tick();
      v += int'(ib.data_valid);
      ib.main_state = MS_CLK18_C;
      tick();
      v += int'(ib.data_valid);
    end
    ib.main_state = MS_WAIT;
    tick();
    v += int'(ib.data_valid);
    chk("t5_lane0", 64'(ib.ADC_data[17:0]), 64'h20000);
    chk("t5_lane1", 64'(ib.ADC_data[35:18]), 64'h1FFFF);
    chk("t5_valid", 64'(v), 64'd1);
    chk("t5_count", 64'(ib.conv_count), 64'd1);

    // Counter wrap: hold the completion slot so every edge publishes
    ia.main_state = MS_CLK1_A;
    ia.channel    = 6'd16;
    repeat (65535) tick();
    chk("t6_count_max", 64'(ia.conv_count), 64'hFFFF);
    ia.main_state = MS_WAIT;
    tick(); tick();
    chk("t6_count_wrap", 64'(ia.conv_count), 64'h0);
    chk("t6_valid_low",  64'(ia.data_valid), 64'h0);
    for (int k = 0; k < 8; k++) model[k] = 16'hA5A5 + 16'(k);

    // No lane enabled: no strobe, no count, words held
    frame_a(16'h7777, 16'h0001, 8'h00, 8'h00, 8'hFF, -1, s, v);
    chk("t7_valid", 64'(v), 64'd0);
    chk("t7_count", 64'(ia.conv_count), 64'h0);
    chk_lanes("t7_data");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
